// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline encodings for the RV32I core: forwarding selects, result
// sources, CtrlD bit-field offsets and ALU operation codes.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwdSelT;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // CtrlD = {ALUControl[2:0], funct3[2:0], ALUSrc, RegWrite, MemWrite, ResultSrc[1:0], Branch, Jump}
  localparam int unsigned CTRL_W        = 13;
  localparam int unsigned CTRL_ALUCTL   = 10;
  localparam int unsigned CTRL_FUNCT3   = 7;
  localparam int unsigned CTRL_ALUSRC   = 6;
  localparam int unsigned CTRL_REGWRITE = 5;
  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_RESSRC   = 2;
  localparam int unsigned CTRL_BRANCH   = 1;
  localparam int unsigned CTRL_JUMP     = 0;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/forwarding_unit.sv
// Selects the forwarding source for each execute-stage operand; MEM beats WB,
// and x0 is never forwarded.
module forwarding_unit
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] Rs1E,
  input  logic [RA_W-1:0] Rs2E,
  input  logic [RA_W-1:0] RdM,
  input  logic            RegWriteM,
  input  logic [RA_W-1:0] RdW,
  input  logic            RegWriteW,
  output fwdSelT          ForwardAE,
  output fwdSelT          ForwardBE
);

  function automatic fwdSelT selectSrc(input logic [RA_W-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
      return FWD_MEM;
    end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  always_comb begin
    ForwardAE = selectSrc(Rs1E);
    ForwardBE = selectSrc(Rs2E);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use detection and
// branch/jump resolution feeding the execute-stage ALU.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              validD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [RA_W-1:0]   Rs1D,
  input  logic [RA_W-1:0]   Rs2D,
  input  logic [RA_W-1:0]   RdD,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [RA_W-1:0]   RdM,
  input  logic              RegWriteM,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [RA_W-1:0]   RdW,
  input  logic              RegWriteW,
  input  logic              branch_taken,
  output logic [XLEN-1:0]   SrcAE,
  output logic [XLEN-1:0]   SrcBE,
  output logic [2:0]        ALUControlE,
  output logic [2:0]        functE,
  output logic [XLEN-1:0]   WriteDataE,
  output logic [RA_W-1:0]   RdE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic [1:0]        ResultSrcE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              PCSrcE,
  output logic              validE,
  output logic              lwStall
);

  logic [CTRL_W-1:0] ctrlE;
  logic [XLEN-1:0]   RD1E, RD2E, ImmExtE, PCE;
  logic [RA_W-1:0]   Rs1E, Rs2E;
  logic              bubble;
  fwdSelT            ForwardAE, ForwardBE;

  assign bubble = FlushE | PCSrcE | lwStall;

  // A stall outranks every bubble source so a held branch keeps redirecting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validE  <= 1'b0;
      ctrlE   <= '0;
      RD1E    <= '0;
      RD2E    <= '0;
      ImmExtE <= '0;
      PCE     <= '0;
      Rs1E    <= '0;
      Rs2E    <= '0;
      RdE     <= '0;
    end else if (!StallE) begin
      if (bubble) begin
        validE  <= 1'b0;
        ctrlE   <= '0;
        RD1E    <= '0;
        RD2E    <= '0;
        ImmExtE <= '0;
        PCE     <= '0;
        Rs1E    <= '0;
        Rs2E    <= '0;
        RdE     <= '0;
      end else begin
        validE  <= validD;
        ctrlE   <= CtrlD;
        RD1E    <= RD1D;
        RD2E    <= RD2D;
        ImmExtE <= ImmExtD;
        PCE     <= PCD;
        Rs1E    <= Rs1D;
        Rs2E    <= Rs2D;
        RdE     <= RdD;
      end
    end
  end

  forwarding_unit #(
    .RA_W(RA_W)
  ) u_fwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .RdW       (RdW),
    .RegWriteW (RegWriteW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
  );

  always_comb begin
    case (ForwardAE)
      FWD_MEM: SrcAE = ALUResultM;
      FWD_WB:  SrcAE = ResultW;
      default: SrcAE = RD1E;
    endcase
    case (ForwardBE)
      FWD_MEM: WriteDataE = ALUResultM;
      FWD_WB:  WriteDataE = ResultW;
      default: WriteDataE = RD2E;
    endcase
  end

  assign SrcBE       = ctrlE[CTRL_ALUSRC] ? ImmExtE : WriteDataE;
  assign ALUControlE = ctrlE[CTRL_ALUCTL +: 3];
  assign functE      = ctrlE[CTRL_FUNCT3 +: 3];
  assign RegWriteE   = ctrlE[CTRL_REGWRITE];
  assign MemWriteE   = ctrlE[CTRL_MEMWRITE];
  assign ResultSrcE  = ctrlE[CTRL_RESSRC +: 2];

  assign PCPlus4E  = PCE + XLEN'(4);
  assign PCTargetE = PCE + ImmExtE;

  assign PCSrcE  = validE & ((ctrlE[CTRL_BRANCH] & branch_taken) | ctrlE[CTRL_JUMP]);
  assign lwStall = validE && (ResultSrcE == RES_MEM) && (RdE != '0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_id_ex_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            StallE, FlushE, validD;
  logic [12:0]     CtrlD;
  logic [31:0]     RD1D, RD2D, ImmExtD, PCD, ALUResultM, ResultW;
  logic [4:0]      Rs1D, Rs2D, RdD, RdM, RdW;
  logic            RegWriteM, RegWriteW, branch_taken;
  logic [31:0]     SrcAE, SrcBE, WriteDataE, PCPlus4E, PCTargetE;
  logic [2:0]      ALUControlE, functE;
  logic [4:0]      RdE;
  logic            RegWriteE, MemWriteE, PCSrcE, validE, lwStall;
  logic [1:0]      ResultSrcE;

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .XLEN(XLEN),
    .RA_W(RA_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .StallE       (StallE),
    .FlushE       (FlushE),
    .validD       (validD),
    .CtrlD        (CtrlD),
    .RD1D         (RD1D),
    .RD2D         (RD2D),
    .ImmExtD      (ImmExtD),
    .PCD          (PCD),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .RdD          (RdD),
    .ALUResultM   (ALUResultM),
    .RdM          (RdM),
    .RegWriteM    (RegWriteM),
    .ResultW      (ResultW),
    .RdW          (RdW),
    .RegWriteW    (RegWriteW),
    .branch_taken (branch_taken),
    .SrcAE        (SrcAE),
    .SrcBE        (SrcBE),
    .ALUControlE  (ALUControlE),
    .functE       (functE),
    .WriteDataE   (WriteDataE),
    .RdE          (RdE),
    .RegWriteE    (RegWriteE),
    .MemWriteE    (MemWriteE),
    .ResultSrcE   (ResultSrcE),
    .PCPlus4E     (PCPlus4E),
    .PCTargetE    (PCTargetE),
    .PCSrcE       (PCSrcE),
    .validE       (validE),
    .lwStall      (lwStall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction held in E, as plain fields.
  logic        mValid;
  logic [12:0] mCtrl;
  logic [31:0] mRD1, mRD2, mImm, mPC;
  logic [4:0]  mRs1, mRs2, mRd;

  function automatic logic [31:0] fwdVal(input logic [4:0] rs, input logic [31:0] rf);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return ALUResultM;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return ResultW;
    return rf;
  endfunction

  function automatic logic expPCSrc();
    return mValid && ((mCtrl[1] && branch_taken) || mCtrl[0]);
  endfunction

  function automatic logic expLw();
    return mValid && (mCtrl[3:2] == 2'b01) && (mRd != 5'd0) && (mRd == Rs1D || mRd == Rs2D);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || (!StallE && (FlushE || expPCSrc() || expLw()))) begin
      mValid <= 1'b0; mCtrl <= '0; mRD1 <= '0; mRD2 <= '0; mImm <= '0; mPC <= '0;
      mRs1 <= '0; mRs2 <= '0; mRd <= '0;
    end else if (!StallE) begin
      mValid <= validD; mCtrl <= CtrlD; mRD1 <= RD1D; mRD2 <= RD2D; mImm <= ImmExtD;
      mPC <= PCD; mRs1 <= Rs1D; mRs2 <= Rs2D; mRd <= RdD;
    end
  end

  logic [31:0] expA, expB;
  always @(negedge clk) begin
    if (cmpEn && !reset) begin
      expA = fwdVal(mRs1, mRD1);
      expB = fwdVal(mRs2, mRD2);
      check("SrcAE", SrcAE, expA);
      check("WriteDataE", WriteDataE, expB);
      check("SrcBE", SrcBE, mCtrl[6] ? mImm : expB);
      check("ALUControlE", 32'(ALUControlE), 32'(mCtrl[12:10]));
      check("functE", 32'(functE), 32'(mCtrl[9:7]));
      check("RdE", 32'(RdE), 32'(mRd));
      check("RegWriteE", 32'(RegWriteE), 32'(mCtrl[5]));
      check("MemWriteE", 32'(MemWriteE), 32'(mCtrl[4]));
      check("ResultSrcE", 32'(ResultSrcE), 32'(mCtrl[3:2]));
      check("PCPlus4E", PCPlus4E, mPC + 32'd4);
      check("PCTargetE", PCTargetE, mPC + mImm);
      check("PCSrcE", 32'(PCSrcE), 32'(expPCSrc()));
      check("validE", 32'(validE), 32'(mValid));
      check("lwStall", 32'(lwStall), 32'(expLw()));
    end
  end

  task automatic clrInputs();
    StallE = 0; FlushE = 0; validD = 0; CtrlD = '0; RD1D = '0; RD2D = '0; ImmExtD = '0;
    PCD = '0; Rs1D = '0; Rs2D = '0; RdD = '0; ALUResultM = '0; RdM = '0; RegWriteM = 0;
    ResultW = '0; RdW = '0; RegWriteW = 0; branch_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clrInputs();
    step();
    step();
    #5 reset = 1'b0;
    cmpEn = 1'b1;

    // Async reset mid-operation clears E before the next edge.
    validD = 1; CtrlD = 13'h020; Rs1D = 5'd2; RD1D = 32'h1234; RdD = 5'd4;
    step();
    check("T1 validE before reset", 32'(validE), 32'h1);
    check("T1 RegWriteE before reset", 32'(RegWriteE), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("T1 validE", 32'(validE), 32'h0);
    check("T1 RegWriteE", 32'(RegWriteE), 32'h0);
    check("T1 PCPlus4E", PCPlus4E, 32'h4);
    check("T1 SrcAE", SrcAE, 32'h0);
    #2 reset = 1'b0;

    // Forwarding priority: MEM over WB over register file.
    clrInputs();
    validD = 1; CtrlD = 13'h020; Rs1D = 5'd5; RD1D = 32'h99; RdD = 5'd7;
    step();
    clrInputs();
    RegWriteM = 1; RdM = 5'd5; ALUResultM = 32'h10;
    RegWriteW = 1; RdW = 5'd5; ResultW = 32'h20;
    #1 check("T2 SrcAE from MEM", SrcAE, 32'h10);
    RegWriteM = 0;
    #1 check("T2 SrcAE from WB", SrcAE, 32'h20);
    RegWriteW = 0;
    #1 check("T2 SrcAE from RF", SrcAE, 32'h99);

    // Load-use hazard.
    clrInputs();
    validD = 1; CtrlD = 13'h064; RdD = 5'd3;
    step();
    clrInputs();
    Rs1D = 5'd1; Rs2D = 5'd3;
    #1 check("T3 lwStall", 32'(lwStall), 32'h1);
    validD = 1; CtrlD = 13'h064; RdD = 5'd0;
    step();
    check("T3 bubble validE", 32'(validE), 32'h0);
    check("T3 bubble RegWriteE", 32'(RegWriteE), 32'h0);
    step();
    clrInputs();
    check("T3 load x0 validE", 32'(validE), 32'h1);
    check("T3 lwStall x0", 32'(lwStall), 32'h0);

    // Taken branch redirects and squashes the next instruction.
    clrInputs();
    validD = 1; CtrlD = 13'h002; PCD = 32'h100; ImmExtD = 32'hFFFF_FFF0;
    step();
    clrInputs();
    branch_taken = 1; validD = 1; CtrlD = 13'h020; RdD = 5'd9;
    #1;
    check("T4 PCSrcE", 32'(PCSrcE), 32'h1);
    check("T4 PCTargetE", PCTargetE, 32'h0000_00F0);
    check("T4 PCPlus4E", PCPlus4E, 32'h0000_0104);
    step();
    check("T4 bubble validE", 32'(validE), 32'h0);

    // Stall outranks flush and redirect.
    clrInputs();
    validD = 1; CtrlD = 13'h002; PCD = 32'h100; ImmExtD = 32'hFFFF_FFF0;
    step();
    clrInputs();
    branch_taken = 1; StallE = 1; FlushE = 1; validD = 1; CtrlD = 13'h020; RdD = 5'd9;
    step();
    check("T5 held validE", 32'(validE), 32'h1);
    check("T5 held PCTargetE", PCTargetE, 32'h0000_00F0);
    check("T5 held PCSrcE", 32'(PCSrcE), 32'h1);
    StallE = 0;
    step();
    check("T5 released validE", 32'(validE), 32'h0);
    check("T5 released PCSrcE", 32'(PCSrcE), 32'h0);
    check("T5 released PCPlus4E", PCPlus4E, 32'h4);

    // PC wrap and store with rs2 forwarded from WB.
    clrInputs();
    validD = 1; CtrlD = 13'h050; PCD = 32'hFFFF_FFFC; ImmExtD = 32'h8;
    Rs2D = 5'd6; RD2D = 32'h55;
    step();
    clrInputs();
    RegWriteW = 1; RdW = 5'd6; ResultW = 32'hABCD;
    #1;
    check("T6 PCPlus4E wrap", PCPlus4E, 32'h0);
    check("T6 PCTargetE wrap", PCTargetE, 32'h4);
    check("T6 SrcBE imm", SrcBE, 32'h8);
    check("T6 WriteDataE", WriteDataE, 32'hABCD);
    check("T6 MemWriteE", 32'(MemWriteE), 32'h1);

    // Randomized traffic; small register indices make hazards frequent.
    for (int i = 0; i < 500; i++) begin
      StallE       = ($urandom_range(0, 7) == 0);
      FlushE       = ($urandom_range(0, 9) == 0);
      validD       = ($urandom_range(0, 3) != 0);
      CtrlD        = 13'($urandom);
      CtrlD[0]     = ($urandom_range(0, 7) == 0);
      RD1D         = $urandom;
      RD2D         = $urandom;
      ImmExtD      = $urandom;
      PCD          = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      Rs1D         = 5'($urandom_range(0, 3));
      Rs2D         = 5'($urandom_range(0, 3));
      RdD          = 5'($urandom_range(0, 3));
      ALUResultM   = $urandom;
      RdM          = 5'($urandom_range(0, 3));
      RegWriteM    = 1'($urandom_range(0, 1));
      ResultW      = $urandom;
      RdW          = 5'($urandom_range(0, 3));
      RegWriteW    = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
